mux_sel_arbiter: RTL and testbench

Round-robin arbiter that shares the 8:1 byte multiplexer between 8 requesters. It drives the mux select, issues a one-hot grant, and bounds each grant with a hold limit. It registers the mux output with source tag and valid. It sits directly in front of the multiplexer select input and behind the requesting agents.

---
 rtl/mux_sel_arbiter.sv | 151 +++++++++++++++
 tb/tb_mux_sel_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving the select of an 8:1 byte multiplexer, with a
// per-owner hold limit and a registered, source-tagged capture of the mux output.
module mux_sel_arbiter #(
    parameter int N_REQ    = 8,
    parameter int SEL_W    = 3,
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_REQ-1:0]  req,
    input  logic [DATA_W-1:0] mux_y,
    output logic [SEL_W-1:0]  select,
    output logic [N_REQ-1:0]  grant,
    output logic              busy,
    output logic [DATA_W-1:0] dout,
    output logic [SEL_W-1:0]  dout_src,
    output logic              dout_valid
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t              state_r;
    logic [SEL_W-1:0]    select_r;
    logic [SEL_W-1:0]    ptr_r;
    logic [N_REQ-1:0]    grant_r;
    logic                busy_r;
    logic [HOLD_W-1:0]   hold_r;
    logic [DATA_W-1:0]   dout_r;
    logic [SEL_W-1:0]    dout_src_r;
    logic                dout_valid_r;

    logic                rel_s;
    logic [SEL_W-1:0]    start_s;
    logic [SEL_W:0]      pick_s;
    logic                found_s;
    logic [SEL_W-1:0]    win_s;

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        return {{(N_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Scan r from start upward with wrap; returns {found, index of first set bit}.
    function automatic logic [SEL_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [SEL_W-1:0] start);
        logic             found;
        logic [SEL_W-1:0] idx;
        logic [SEL_W-1:0] cand;
        found = 1'b0;
        idx   = {SEL_W{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            cand  = start + i[SEL_W-1:0];
            idx   = (!found && r[cand]) ? cand : idx;
            found = found | r[cand];
        end
        return {found, idx};
    endfunction

    // Release decision and next-winner selection for the current cycle.
    always_comb begin
        rel_s = 1'b0;
        if (state_r == ST_BUSY) begin
            rel_s = !req[select_r] ||
                    ((hold_r == HOLD_MAX) && ((req & ~onehot(select_r)) != {N_REQ{1'b0}}));
        end else begin
            rel_s = 1'b0;
        end
        start_s = (state_r == ST_BUSY) ? (select_r + SEL_W'(1)) : ptr_r;
        pick_s  = rr_pick(req, start_s);
        found_s = pick_s[SEL_W];
        win_s   = pick_s[SEL_W-1:0];
    end

    // Arbitration state, grant/select registers and mux output capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            select_r     <= {SEL_W{1'b0}};
            ptr_r        <= {SEL_W{1'b0}};
            grant_r      <= {N_REQ{1'b0}};
            busy_r       <= 1'b0;
            hold_r       <= {HOLD_W{1'b0}};
            dout_r       <= {DATA_W{1'b0}};
            dout_src_r   <= {SEL_W{1'b0}};
            dout_valid_r <= 1'b0;
        end else begin
            if (grant_r != {N_REQ{1'b0}}) begin
                dout_r       <= mux_y;
                dout_src_r   <= select_r;
                dout_valid_r <= 1'b1;
            end else begin
                dout_valid_r <= 1'b0;
            end

            case (state_r)
                ST_IDLE: begin
                    if (found_s) begin
                        grant_r  <= onehot(win_s);
                        select_r <= win_s;
                        busy_r   <= 1'b1;
                        hold_r   <= HOLD_ONE;
                        state_r  <= ST_BUSY;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (rel_s) begin
                        ptr_r <= select_r + SEL_W'(1);
                        // Hand over in the same edge so owners are back-to-back.
                        if (found_s) begin
                            grant_r  <= onehot(win_s);
                            select_r <= win_s;
                            busy_r   <= 1'b1;
                            hold_r   <= HOLD_ONE;
                            state_r  <= ST_BUSY;
                        end else begin
                            grant_r  <= {N_REQ{1'b0}};
                            busy_r   <= 1'b0;
                            hold_r   <= {HOLD_W{1'b0}};
                            state_r  <= ST_IDLE;
                        end
                    end else begin
                        hold_r <= (hold_r == HOLD_MAX) ? HOLD_MAX : (hold_r + HOLD_ONE);
                    end
                end
                default: begin
                    grant_r <= {N_REQ{1'b0}};
                    busy_r  <= 1'b0;
                    hold_r  <= {HOLD_W{1'b0}};
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign select     = select_r;
    assign grant      = grant_r;
    assign busy       = busy_r;
    assign dout       = dout_r;
    assign dout_src   = dout_src_r;
    assign dout_valid = dout_valid_r;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Table-driven bench for mux_sel_arbiter with a scoreboard queue of expected
// captured words, plus hand-written hold-limit and async-reset sequences.
module tb_mux_sel_arbiter;

    logic       clk;
    logic       reset;
    logic [7:0] req;
    logic [7:0] mux_y;
    logic [2:0] select;
    logic [7:0] grant;
    logic       busy;
    logic [7:0] dout;
    logic [2:0] dout_src;
    logic       dout_valid;

    logic [7:0] mux_data [8];

    typedef struct {
        logic [7:0] req;
        logic [7:0] exp_grant;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic [2:0] src;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   n_checks;
    int   n_fail;

    mux_sel_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .mux_y      (mux_y),
        .select     (select),
        .grant      (grant),
        .busy       (busy),
        .dout       (dout),
        .dout_src   (dout_src),
        .dout_valid (dout_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mux_y = mux_data[select];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] idx_of(input logic [7:0] g);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (g[i]) r = i[2:0];
        end
        return r;
    endfunction

    task automatic add(input logic [7:0] r, input logic [7:0] eg, input int n);
        vec_t v;
        v.req       = r;
        v.exp_grant = eg;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    // One clock: drive req, check grant side, pop/compare the scoreboard.
    task automatic step(input logic [7:0] r, input logic [7:0] eg, input string tag);
        sb_t e;
        logic [2:0] ix;
        req = r;
        @(posedge clk);
        #1;
        chk({tag, " grant"}, 32'(grant), 32'(eg));
        chk({tag, " busy"}, 32'(busy), 32'(eg != 8'h00));
        ix = idx_of(eg);
        if (eg != 8'h00) chk({tag, " select"}, 32'(select), 32'(ix));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, " dout_valid"}, 32'(dout_valid), 32'd1);
            chk({tag, " dout"}, 32'(dout), 32'(e.data));
            chk({tag, " dout_src"}, 32'(dout_src), 32'(e.src));
        end else begin
            chk({tag, " dout_valid idle"}, 32'(dout_valid), 32'd0);
        end
        if (eg != 8'h00) begin
            e.data = mux_data[ix];
            e.src  = ix;
            sb.push_back(e);
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, " grant"}, 32'(grant), 32'd0);
        chk({tag, " select"}, 32'(select), 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " dout"}, 32'(dout), 32'd0);
        chk({tag, " dout_src"}, 32'(dout_src), 32'd0);
        chk({tag, " dout_valid"}, 32'(dout_valid), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req   = 8'h00;
        #1;
        sb.delete();
        check_reset_state("reset");
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        mux_data[0] = 8'h00; mux_data[1] = 8'hA1; mux_data[2] = 8'hA2; mux_data[3] = 8'hA3;
        mux_data[4] = 8'hB4; mux_data[5] = 8'hB5; mux_data[6] = 8'hB6; mux_data[7] = 8'hB7;
        reset = 1'b0;
        req   = 8'h00;
        #12;
        do_reset();

        // Single requester, then idle.
        add(8'h08, 8'h08, 3);
        add(8'h00, 8'h00, 2);
        // Owner 5 hits the hold limit; scan from 6 wraps to 0.
        add(8'h20, 8'h20, 1);
        add(8'h21, 8'h20, 3);
        add(8'h21, 8'h01, 1);
        add(8'h00, 8'h00, 2);
        // Sole requester keeps the grant past the hold limit.
        add(8'h80, 8'h80, 10);
        add(8'h00, 8'h00, 2);
        // Move ptr to 2, then owner 2 drops early and 1 takes over via wrap.
        add(8'h02, 8'h02, 1);
        add(8'h00, 8'h00, 2);
        add(8'h06, 8'h04, 2);
        add(8'h02, 8'h02, 1);
        add(8'h00, 8'h00, 2);
        foreach (vecs[i]) step(vecs[i].req, vecs[i].exp_grant, $sformatf("vec%0d", i));

        // All requesting: each index owns exactly 4 cycles, in order.
        do_reset();
        for (int e = 0; e < 33; e++) begin
            step(8'hFF, 8'h01 << ((e / 4) % 8), $sformatf("all_req%0d", e));
        end
        step(8'h00, 8'h00, "all_req_drop");
        step(8'h00, 8'h00, "all_req_idle");

        // Asynchronous reset in the middle of a grant.
        do_reset();
        step(8'h10, 8'h10, "mid_a");
        step(8'h10, 8'h10, "mid_b");
        #2;
        reset = 1'b0;
        #1;
        sb.delete();
        check_reset_state("async_rst");
        req = 8'h11;
        #2;
        reset = 1'b1;
        step(8'h11, 8'h01, "post_rst");
        step(8'h01, 8'h01, "post_rst2");
        step(8'h00, 8'h00, "post_rst3");
        step(8'h00, 8'h00, "post_rst4");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
